// File: rtl/exe_task_dispatcher.sv
// Task dispatcher for the execution unit: FIFO of pending entry addresses, one task
// in flight (trigger -> wait for done or timeout), result record on a valid/ready port.
module exe_task_dispatcher #(
  parameter int ROM_ADDRESS_WIDTH = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              iTaskValid,
  input  logic [ROM_ADDRESS_WIDTH-1:0]      iTaskAddress,
  output logic                              oTaskReady,
  output logic                              oExeTrigger,
  output logic [ROM_ADDRESS_WIDTH-1:0]      oExeInitialCodeAddress,
  input  logic                              iExeDone,
  input  logic                              iExeReturnCode,
  output logic                              oResultValid,
  output logic [ROM_ADDRESS_WIDTH-1:0]      oResultAddress,
  output logic                              oResultCode,
  output logic                              oResultTimeout,
  input  logic                              iResultReady,
  output logic                              oBusy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   oPending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRIGGER = 2'd1,
    S_WAIT    = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  logic [ROM_ADDRESS_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         ready_q, ready_d;
  logic [ROM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                         trigger_q, trigger_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic                         res_valid_q, res_valid_d;
  logic                         res_code_q, res_code_d;
  logic                         res_timeout_q, res_timeout_d;
  logic                         busy_q, busy_d;

  logic push;
  logic pop;

  // Pop looks only at the registered count, so a fresh push is never bypassed.
  assign push = iTaskValid & ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= iTaskAddress;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    timer_d       = timer_q;
    res_valid_d   = res_valid_q;
    res_code_d    = res_code_q;
    res_timeout_d = res_timeout_q;
    trigger_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          addr_d    = fifo_mem[rd_ptr_q];
          trigger_d = 1'b1;
          state_d   = S_TRIGGER;
        end
      end
      S_TRIGGER: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done sampled in the same cycle as the timeout still wins.
        if (iExeDone) begin
          res_valid_d   = 1'b1;
          res_code_d    = iExeReturnCode;
          res_timeout_d = 1'b0;
          state_d       = S_REPORT;
        end else begin
          timer_d = timer_q + 1'b1;
          if (TIMEOUT_EN && (timer_q == TMR_LAST)) begin
            res_valid_d   = 1'b1;
            res_code_d    = 1'b0;
            res_timeout_d = 1'b1;
            state_d       = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (iResultReady) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      addr_q        <= '0;
      trigger_q     <= 1'b0;
      timer_q       <= '0;
      res_valid_q   <= 1'b0;
      res_code_q    <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      addr_q        <= addr_d;
      trigger_q     <= trigger_d;
      timer_q       <= timer_d;
      res_valid_q   <= res_valid_d;
      res_code_q    <= res_code_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign oTaskReady             = ready_q;
  assign oExeTrigger            = trigger_q;
  assign oExeInitialCodeAddress = addr_q;
  assign oResultValid           = res_valid_q;
  assign oResultAddress         = addr_q;
  assign oResultCode            = res_code_q;
  assign oResultTimeout         = res_timeout_q;
  assign oBusy                  = busy_q;
  assign oPending               = count_q;

endmodule

// File: tb/tb_exe_task_dispatcher.sv
// Bench for exe_task_dispatcher: queue-based behavioural model compared every cycle,
// plus directed scenarios with hand-computed cycle/record expectations.
module tb_exe_task_dispatcher;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tv = 1'b0;
  logic [15:0] ta = 16'h0;
  logic        done = 1'b0;
  logic        rc = 1'b0;
  logic        rr = 1'b1;

  logic        task_ready, exe_trig, res_valid, res_code, res_to, busy;
  logic [15:0] exe_addr, res_addr;
  logic [2:0]  pending;

  exe_task_dispatcher #(
    .ROM_ADDRESS_WIDTH(16),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .iTaskValid(tv),
    .iTaskAddress(ta),
    .oTaskReady(task_ready),
    .oExeTrigger(exe_trig),
    .oExeInitialCodeAddress(exe_addr),
    .iExeDone(done),
    .iExeReturnCode(rc),
    .oResultValid(res_valid),
    .oResultAddress(res_addr),
    .oResultCode(res_code),
    .oResultTimeout(res_to),
    .iResultReady(rr),
    .oBusy(busy),
    .oPending(pending)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: pending queue, one task lifecycle, age = WAIT cycles so far.
  logic [15:0] mq[$];
  bit          m_busy = 0;
  int          m_age = 0;
  bit          m_rv = 0;
  bit          m_code = 0;
  bit          m_to = 0;
  logic [15:0] m_addr = 16'h0;
  bit          m_ready = 0;
  bit          m_push;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_busy = 0; m_age = 0; m_rv = 0; m_code = 0; m_to = 0;
        m_addr = 16'h0; m_ready = 0;
      end else begin
        m_push = tv && m_ready;
        if (!m_busy) begin
          if (mq.size() > 0) begin
            m_addr = mq.pop_front();
            m_busy = 1;
            m_age  = 0;
          end
        end else if (!m_rv) begin
          if (m_age == 0) m_age = 1;
          else if (done) begin
            m_rv = 1; m_code = rc; m_to = 0;
          end else if (m_age == TO) begin
            m_rv = 1; m_code = 0; m_to = 1;
          end else m_age++;
        end else if (rr) begin
          m_rv = 0;
          m_busy = 0;
        end
        if (m_push) mq.push_back(ta);
        m_ready = (mq.size() != DEPTH);
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_ready",   32'(task_ready), 32'(m_ready));
      chk("cmp_trigger", 32'(exe_trig),   32'(m_busy && !m_rv && m_age == 0));
      chk("cmp_busy",    32'(busy),       32'(m_busy));
      chk("cmp_pending", 32'(pending),    32'(mq.size()));
      chk("cmp_exeaddr", 32'(exe_addr),   32'(m_addr));
      chk("cmp_valid",   32'(res_valid),  32'(m_rv));
      if (m_rv) begin
        chk("cmp_resaddr", 32'(res_addr), 32'(m_addr));
        chk("cmp_rescode", 32'(res_code), 32'(m_code));
        chk("cmp_resto",   32'(res_to),   32'(m_to));
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic        c;
    logic        t;
    int unsigned cy;
  } rec_t;
  rec_t        recs[$];
  int unsigned trigs[$];

  always @(posedge clk) begin
    if (res_valid && rr) recs.push_back('{res_addr, res_code, res_to, cyc});
    if (exe_trig) trigs.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] a, output int unsigned n);
    tv = 1'b1;
    ta = a;
    tick();
    tv = 1'b0;
    n = cyc;
  endtask

  task automatic wait_trig(input string nm, output int unsigned c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      if (exe_trig) begin
        found = 1;
        c = cyc;
        break;
      end
      tick();
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic wait_rec(input string nm, input int n);
    for (int i = 0; i < 200 && recs.size() < n; i++) tick();
    chk(nm, 32'(recs.size()), 32'(n));
  endtask

  initial begin
    int unsigned n0, tc, tc2;
    int base, ntr;
    bit seen;

    // Reset and release
    repeat (3) tick();
    chk("ready_in_reset", 32'(task_ready), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(task_ready), 32'd1);
    chk("pending_after_release", 32'(pending), 32'd0);

    // T1: single task, done 5 cycles after the trigger cycle, code 1
    base = recs.size();
    push(16'h0040, n0);
    wait_trig("t1_trig_found", tc);
    chk("t1_trig_latency", tc, n0 + 1);
    chk("t1_exe_addr", 32'(exe_addr), 32'h0040);
    repeat (5) tick();
    done = 1'b1; rc = 1'b1;
    tick();
    done = 1'b0; rc = 1'b0;
    wait_rec("t1_rec_count", base + 1);
    chk("t1_rec_addr", 32'(recs[base].a), 32'h0040);
    chk("t1_rec_code", 32'(recs[base].c), 32'd1);
    chk("t1_rec_to",   32'(recs[base].t), 32'd0);
    chk("t1_rec_cycle", recs[base].cy, tc + 6);
    repeat (2) tick();

    // T2: six back-to-back pushes with done withheld; sixth is back-pressured
    base = recs.size();
    tv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ta = 16'h0200 + 16'(i);
      tick();
    end
    chk("t2_pending_full", 32'(pending), 32'd4);
    chk("t2_ready_full",   32'(task_ready), 32'd0);
    repeat (3) tick();
    tv = 1'b0;
    wait_rec("t2_rec_count", base + 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 32'(recs[base + i].a), 32'h0200 + 32'(i));
      chk("t2_timeout", 32'(recs[base + i].t), 32'd1);
    end
    repeat (2) tick();

    // T3: timeout after 8 WAIT cycles, then a normal task
    base = recs.size();
    push(16'h0300, n0);
    wait_trig("t3_trig_found", tc);
    wait_rec("t3_rec_count", base + 1);
    chk("t3_rec_cycle", recs[base].cy, tc + 9);
    chk("t3_rec_to",    32'(recs[base].t), 32'd1);
    chk("t3_rec_code",  32'(recs[base].c), 32'd0);
    push(16'h0301, n0);
    wait_trig("t3b_trig_found", tc);
    repeat (3) tick();
    done = 1'b1; rc = 1'b1;
    tick();
    done = 1'b0; rc = 1'b0;
    wait_rec("t3b_rec_count", base + 2);
    chk("t3b_rec_to",   32'(recs[base + 1].t), 32'd0);
    chk("t3b_rec_code", 32'(recs[base + 1].c), 32'd1);
    repeat (2) tick();

    // T4: consumer stalls 10 cycles; next trigger 2 cycles after the accept
    base = recs.size();
    rr = 1'b0;
    push(16'h0400, n0);
    push(16'h0401, n0);
    wait_trig("t4_trig_found", tc);
    repeat (2) tick();
    done = 1'b1; rc = 1'b1;
    tick();
    done = 1'b0; rc = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("t4_valid_seen", 32'(seen), 32'd1);
    ntr = trigs.size();
    repeat (10) tick();
    chk("t4_no_trigger", 32'(trigs.size()), 32'(ntr));
    chk("t4_pending", 32'(pending), 32'd1);
    rr = 1'b1;
    tick();
    rr = 1'b0;
    wait_trig("t4b_trig_found", tc2);
    chk("t4_accept_to_trig", tc2, recs[base].cy + 2);
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    rr = 1'b1;
    wait_rec("t4_rec_count", base + 2);
    repeat (2) tick();

    // T5: done held high through the next task's TRIGGER must not complete it
    base = recs.size();
    push(16'h0500, n0);
    push(16'h0501, n0);
    wait_trig("t5_trig_found", tc);
    tick();
    done = 1'b1; rc = 1'b1;
    wait_trig("t5b_trig_found", tc2);
    tick();
    done = 1'b0; rc = 1'b0;
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_rec("t5_rec_count", base + 2);
    chk("t5_first_code", 32'(recs[base].c), 32'd1);
    chk("t5_second_addr", 32'(recs[base + 1].a), 32'h0501);
    chk("t5_second_code", 32'(recs[base + 1].c), 32'd0);
    chk("t5_second_cycle", recs[base + 1].cy, tc2 + 5);
    repeat (2) tick();

    // T6: reset during WAIT with three tasks queued
    for (int i = 0; i < 4; i++) push(16'h0600 + 16'(i), n0);
    chk("t6_pending_before", 32'(pending), 32'd3);
    tick();
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_busy",    32'(busy), 32'd0);
    chk("t6_rst_ready",   32'(task_ready), 32'd0);
    chk("t6_rst_valid",   32'(res_valid), 32'd0);
    chk("t6_rst_trigger", 32'(exe_trig), 32'd0);
    chk("t6_rst_exeaddr", 32'(exe_addr), 32'd0);
    base = recs.size();
    ntr = trigs.size();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (15) tick();
    chk("t6_no_record",  32'(recs.size()), 32'(base));
    chk("t6_no_trigger", 32'(trigs.size()), 32'(ntr));
    chk("t6_pending_after", 32'(pending), 32'd0);
    chk("t6_ready_after", 32'(task_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
